// File: rtl/ysyx_25060170_mem_arb.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Latency: request sampled in IDLE -> mem_req next cycle -> response passed through combinationally on mem_rvalid.
// Backpressure: mem_req held with stable latched fields until mem_gnt; watchdog aborts a stalled response.
module ysyx_25060170_mem_arb #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch master
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  input  logic        ifu_kill,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  // load/store master
  input  logic        lsu_req,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  // shared memory port
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        owner,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    LSU_REQ  = 3'd3,
    LSU_WAIT = 3'd4
  } state_t;

  // The watchdog fires in the TIMEOUT_CYC-th WAIT cycle, i.e. when the
  // counter (cleared on entry) still reads TIMEOUT_CYC-1 and nothing arrived.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nxt;

  logic        last_grant;   // 0 = IFU was granted last, 1 = LSU
  logic [15:0] wd_cnt;
  logic        kill_flag;

  logic        lat_wen;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;

  logic        grant_ifu;
  logic        grant_lsu;
  logic        in_wait;
  logic        wd_expire;
  logic        ifu_drop;
  logic        ifu_done;

  assign in_wait   = (state == IFU_WAIT) || (state == LSU_WAIT);
  // A real response in the expiry cycle wins over the timeout.
  assign wd_expire = in_wait && !mem_rvalid && (wd_cnt == WD_LAST);
  // A kill seen in the completing cycle itself also discards the response.
  assign ifu_drop  = kill_flag || ifu_kill;
  assign ifu_done  = (state == IFU_WAIT) && (mem_rvalid || wd_expire);

  // Memory fields come only from the latched copy of the winner's request.
  assign mem_wen   = lat_wen;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_wmask = lat_wmask;

  // Round-robin pick in IDLE: a lone requester wins, contention goes to the master not granted last.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE) begin
      if (ifu_req && lsu_req) begin
        if (last_grant) grant_ifu = 1'b1;
        else            grant_lsu = 1'b1;
      end else if (ifu_req) begin
        grant_ifu = 1'b1;
      end else if (lsu_req) begin
        grant_lsu = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state outputs; responses are steered to the owner only.
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    busy       = 1'b1;
    owner      = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rdata  = 32'h0;
    ifu_err    = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = 32'h0;
    lsu_err    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_ifu)      state_nxt = IFU_REQ;
        else if (grant_lsu) state_nxt = LSU_REQ;
      end
      IFU_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (mem_rvalid || wd_expire) begin
          state_nxt  = IDLE;
          ifu_rvalid = !ifu_drop;
          ifu_err    = !ifu_drop && !mem_rvalid;
          ifu_rdata  = (!ifu_drop && mem_rvalid) ? mem_rdata : 32'h0;
        end
      end
      LSU_REQ: begin
        owner   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = LSU_WAIT;
      end
      LSU_WAIT: begin
        owner = 1'b1;
        if (mem_rvalid || wd_expire) begin
          state_nxt  = IDLE;
          lsu_rvalid = 1'b1;
          lsu_err    = !mem_rvalid;
          lsu_rdata  = mem_rvalid ? mem_rdata : 32'h0;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  // Capture the winner's request and remember who was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
      lat_wen    <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_wmask  <= 4'h0;
    end else if (grant_ifu) begin
      last_grant <= 1'b0;
      lat_wen    <= 1'b0;
      lat_addr   <= ifu_addr;
      lat_wdata  <= 32'h0;
      lat_wmask  <= 4'h0;
    end else if (grant_lsu) begin
      last_grant <= 1'b1;
      lat_wen    <= lsu_wen;
      lat_addr   <= lsu_addr;
      lat_wdata  <= lsu_wdata;
      lat_wmask  <= lsu_wmask;
    end
  end

  // Watchdog: restart on the grant handshake, count idle WAIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= 16'h0;
    end else if (((state == IFU_REQ) || (state == LSU_REQ)) && mem_gnt) begin
      wd_cnt <= 16'h0;
    end else if (in_wait && !mem_rvalid && !wd_expire) begin
      wd_cnt <= wd_cnt + 16'h1;
    end
  end

  // Kill flag: remembers a discarded fetch until its bus transaction finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      kill_flag <= 1'b0;
    end else if (ifu_done) begin
      kill_flag <= 1'b0;
    end else if (((state == IFU_REQ) || (state == IFU_WAIT)) && ifu_kill) begin
      kill_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter.
// Inputs are driven 1ns after each rising edge and outputs sampled 1ns later.
// Each task covers one scenario with inline expected-value comparisons.
module tb_ysyx_25060170_mem_arb;

  logic        clk;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_kill;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_req;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        owner;
  logic        busy;

  int total = 0;
  int bad   = 0;

  ysyx_25060170_mem_arb #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_kill(ifu_kill),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ifu_req = 0; ifu_addr = 0; ifu_kill = 0;
    lsu_req = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic test_reset;
    rst = 1; clear_inputs();
    ifu_req = 1; lsu_req = 1; mem_gnt = 1; mem_rvalid = 1;
    tick(); tick();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    total++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got ifu=%b lsu=%b want 0 0", ifu_rvalid, lsu_rvalid); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner: got %b want 0", owner); end
    total++; if (mem_addr !== 32'h0 || mem_wmask !== 4'h0) begin bad++; $display("FAIL reset_fields: got addr=%h wmask=%h want 0 0", mem_addr, mem_wmask); end
    rst = 0; clear_inputs();
    tick();
  endtask

  task automatic test_ifu_fetch;
    ifu_req = 1; ifu_addr = 32'h8000_0000; mem_gnt = 1;
    #1;
    total++; if (ifu_rvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL fetch_t0: got rvalid=%b busy=%b want 0 0", ifu_rvalid, busy); end
    tick();
    #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL fetch_req: got req=%b addr=%h want 1 80000000", mem_req, mem_addr); end
    total++; if (mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin bad++; $display("FAIL fetch_wen: got wen=%b wmask=%h want 0 0", mem_wen, mem_wmask); end
    total++; if (owner !== 1'b0 || busy !== 1'b1 || ifu_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_t1: got owner=%b busy=%b rvalid=%b want 0 1 0", owner, busy, ifu_rvalid); end
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0000_0413;
    #1;
    total++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || ifu_err !== 1'b0) begin bad++; $display("FAIL fetch_resp: got rvalid=%b rdata=%h err=%b want 1 00000413 0", ifu_rvalid, ifu_rdata, ifu_err); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_wait_req: got %b want 0", mem_req); end
    total++; if (lsu_rvalid !== 1'b0 || lsu_rdata !== 32'h0 || lsu_err !== 1'b0) begin bad++; $display("FAIL fetch_lsu_quiet: got rvalid=%b rdata=%h err=%b want 0 0 0", lsu_rvalid, lsu_rdata, lsu_err); end
    tick();
    clear_inputs();
    #1;
    total++; if (busy !== 1'b0 || ifu_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_idle: got busy=%b rvalid=%b want 0 0", busy, ifu_rvalid); end
  endtask

  task automatic test_contention;
    rst = 1; tick();
    rst = 0;
    ifu_req = 1; ifu_addr = 32'h8000_0100;
    lsu_req = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    mem_gnt = 1;
    for (int k = 0; k < 4; k++) begin
      logic        exp_lsu;
      logic [31:0] exp_addr;
      logic [31:0] got_rdata;
      exp_lsu  = (k % 2 == 0);
      exp_addr = exp_lsu ? 32'h8000_2000 : 32'h8000_0100;
      tick();
      #1;
      total++; if (owner !== exp_lsu || mem_req !== 1'b1 || mem_addr !== exp_addr) begin bad++; $display("FAIL contend_grant%0d: got owner=%b req=%b addr=%h want %b 1 %h", k, owner, mem_req, mem_addr, exp_lsu, exp_addr); end
      tick();
      mem_rvalid = 1; mem_rdata = 32'hA0 + k;
      #1;
      got_rdata = exp_lsu ? lsu_rdata : ifu_rdata;
      total++; if (lsu_rvalid !== exp_lsu || ifu_rvalid !== !exp_lsu || got_rdata !== 32'hA0 + k) begin bad++; $display("FAIL contend_resp%0d: got lsu=%b ifu=%b rdata=%h want %b %b %h", k, lsu_rvalid, ifu_rvalid, got_rdata, exp_lsu, !exp_lsu, 32'hA0 + k); end
      tick();
      mem_rvalid = 0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL contend_idle%0d: got busy=%b want 0", k, busy); end
    end
    clear_inputs();
  endtask

  task automatic test_lsu_store;
    lsu_req = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; mem_gnt = 0;
    ifu_kill = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) lsu_wdata = 32'h0BAD_0BAD;
      mem_gnt = (i == 2);
      #1;
      total++; if (mem_req !== 1'b1 || owner !== 1'b1) begin bad++; $display("FAIL store_req%0d: got req=%b owner=%b want 1 1", i, mem_req, owner); end
      total++; if (mem_wen !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'b0011) begin bad++; $display("FAIL store_fields%0d: got wen=%b addr=%h wdata=%h wmask=%b want 1 80001000 deadbeef 0011", i, mem_wen, mem_addr, mem_wdata, mem_wmask); end
    end
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL store_wait_req: got %b want 0", mem_req); end
    total++; if (lsu_rvalid !== 1'b1 || lsu_err !== 1'b0 || ifu_rvalid !== 1'b0) begin bad++; $display("FAIL store_resp: got lsu=%b err=%b ifu=%b want 1 0 0", lsu_rvalid, lsu_err, ifu_rvalid); end
    tick();
    clear_inputs();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL store_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_timeout;
    ifu_req = 1; ifu_addr = 32'h8000_0200; mem_gnt = 1;
    tick();
    tick();
    mem_gnt = 0; mem_rdata = 32'hFFFF_FFFF;
    for (int w = 1; w <= 4; w++) begin
      if (w > 1) tick();
      #1;
      total++; if (ifu_rvalid !== (w == 4) || busy !== 1'b1) begin bad++; $display("FAIL timeout_w%0d: got rvalid=%b busy=%b want %b 1", w, ifu_rvalid, busy, (w == 4)); end
    end
    total++; if (ifu_err !== 1'b1 || ifu_rdata !== 32'h0 || lsu_rvalid !== 1'b0) begin bad++; $display("FAIL timeout_err: got err=%b rdata=%h lsu=%b want 1 0 0", ifu_err, ifu_rdata, lsu_rvalid); end
    tick();
    ifu_req = 0; mem_rvalid = 1;
    #1;
    total++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_late: got ifu=%b lsu=%b busy=%b want 0 0 0", ifu_rvalid, lsu_rvalid, busy); end
    tick();
    mem_rvalid = 0;
    ifu_req = 1; mem_gnt = 1;
    tick();
    tick();
    mem_gnt = 0;
    for (int w = 1; w <= 4; w++) begin
      if (w > 1) tick();
      if (w == 4) begin mem_rvalid = 1; mem_rdata = 32'h1234_5678; end
      #1;
      total++; if (ifu_rvalid !== (w == 4)) begin bad++; $display("FAIL tie_w%0d: got rvalid=%b want %b", w, ifu_rvalid, (w == 4)); end
    end
    total++; if (ifu_err !== 1'b0 || ifu_rdata !== 32'h1234_5678) begin bad++; $display("FAIL tie_resp: got err=%b rdata=%h want 0 12345678", ifu_err, ifu_rdata); end
    tick();
    clear_inputs();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tie_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_kill;
    ifu_req = 1; ifu_addr = 32'h8000_0300; mem_gnt = 1;
    tick();
    tick();
    ifu_kill = 1; mem_gnt = 0;
    #1;
    total++; if (ifu_rvalid !== 1'b0) begin bad++; $display("FAIL kill_w1: got rvalid=%b want 0", ifu_rvalid); end
    tick();
    ifu_kill = 0;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL kill_w2_busy: got %b want 1", busy); end
    tick();
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    #1;
    total++; if (ifu_rvalid !== 1'b0 || ifu_err !== 1'b0 || ifu_rdata !== 32'h0) begin bad++; $display("FAIL kill_resp: got rvalid=%b err=%b rdata=%h want 0 0 0", ifu_rvalid, ifu_err, ifu_rdata); end
    tick();
    mem_rvalid = 0; ifu_addr = 32'h8000_0304; mem_gnt = 1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_busy_drop: got %b want 0", busy); end
    tick();
    #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0304) begin bad++; $display("FAIL kill_next_req: got req=%b addr=%h want 1 80000304", mem_req, mem_addr); end
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    #1;
    total++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0013) begin bad++; $display("FAIL kill_next_resp: got rvalid=%b rdata=%h want 1 00000013", ifu_rvalid, ifu_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    lsu_req = 1; lsu_addr = 32'h8000_4000; mem_gnt = 1;
    tick();
    #1;
    total++; if (owner !== 1'b1 || mem_req !== 1'b1) begin bad++; $display("FAIL rmid_req: got owner=%b req=%b want 1 1", owner, mem_req); end
    tick();
    rst = 1; mem_gnt = 0;
    #1;
    total++; if (lsu_rvalid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rmid_wait: got rvalid=%b busy=%b want 0 1", lsu_rvalid, busy); end
    tick();
    rst = 0; ifu_req = 1; ifu_addr = 32'h8000_0400; lsu_req = 1; mem_rvalid = 1; mem_gnt = 1;
    #1;
    total++; if (busy !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rmid_abort: got busy=%b req=%b want 0 0", busy, mem_req); end
    total++; if (lsu_rvalid !== 1'b0 || ifu_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_nopulse: got lsu=%b ifu=%b want 0 0", lsu_rvalid, ifu_rvalid); end
    tick();
    mem_rvalid = 0;
    #1;
    total++; if (owner !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h8000_4000) begin bad++; $display("FAIL rmid_regrant: got owner=%b req=%b addr=%h want 1 1 80004000", owner, mem_req, mem_addr); end
    tick();
    lsu_req = 0; ifu_req = 0; mem_gnt = 0; mem_rvalid = 1;
    #1;
    total++; if (lsu_rvalid !== 1'b1) begin bad++; $display("FAIL rmid_resp: got %b want 1", lsu_rvalid); end
    tick();
    clear_inputs();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_ifu_fetch();
    test_contention();
    test_lsu_store();
    test_timeout();
    test_kill();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
